cyc_24_pucch1_despread: RTL
===========================

Name: cyc_24_pucch1_despread

Overview:
Receive-side counterpart of the PUCCH format 1 block-wise spreader. It takes the per-symbol complex values of one frequency hop, already correlated against the base sequence, and removes the time-domain orthogonal cover wi(m) = exp(j*2*pi*phi(m)/24) by multiplying each value by conj(wi(m)). It then coherently sums the nSF derotated values into one complex statistic per hop, which feeds the PUCCH1 UCI detector.

Parameters:
W, 16, width of signed input I/Q samples
CW, 16, width of signed twiddle coefficients (Q2.(CW-2); 1.0 = 2^(CW-2))
OW, W+4, width of signed accumulated output I/Q

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_start  input  1  begin a hop; samples i_nSF and i_occi
i_nSF  input  3  spreading factor for this hop; 1,2,3,4,6 supported
i_occi  input  3  orthogonal cover code index, valid range 0..nSF-1
i_valid  input  1  i_re/i_im carry symbol m of the current hop
i_re  input  W  signed in-phase sample
i_im  input  W  signed quadrature sample
o_busy  output  1  hop in progress; samples accepted only while high
o_valid  output  1  one-cycle pulse; o_re/o_im hold the hop result
o_re  output  OW  signed despread sum, in-phase
o_im  output  OW  signed despread sum, quadrature
o_err  output  1  one-cycle pulse on unsupported nSF or occi >= nSF

Behaviour:
- Reset values: o_busy=0, o_valid=0, o_err=0, o_re=0, o_im=0. State returns to IDLE, m=0, pipeline is cleared.
- States: IDLE, ACCUM, DRAIN.
- IDLE + i_start with supported nSF and occi<nSF: latch nSF/occi, m<=0, clear accumulator, go to ACCUM (o_busy=1 from the next cycle).
- IDLE + i_start with nSF in {0,5,7} or occi>=nSF: o_err=1 for the next cycle, stay IDLE.
- ACCUM: each cycle with i_valid=1 accepts symbol m and increments m. Accepting symbol nSF-1 moves to DRAIN (o_busy=0 next cycle). i_valid is ignored in IDLE and DRAIN.
- Phase phi(m), in units of 2*pi/24:
  - nSF!=4: phi(m) = (m*occi*A) mod 24, with A = 0, 12, 8, 4 for nSF = 1, 2, 3, 6. Generate it incrementally: phi(0)=0, then phi += occi*A, subtract 24 when the sum is >= 24.
  - nSF=4: phi(m) is 0 or 12, taken from a LUT indexed by occi and m:
    - occi0: 0 0 0 0
    - occi1: 0 12 0 12
    - occi2: 0 0 12 12
    - occi3: 0 12 12 0
- All phi values are multiples of 4, so the twiddle ROM has 6 entries (k = phi/4). It returns c = round(cos(2*pi*k/6)*2^(CW-2)) and s = round(sin(2*pi*k/6)*2^(CW-2)).
- Derotation (stage 1, registered): re = xr*c + xi*s and im = xi*c - xr*s. Round half-up, shift right by CW-2, sign-extend to OW.
- Accumulate (stage 2): acc += product. This cannot overflow for nSF<=6 with OW=W+4.
- Latency: o_valid pulses exactly 2 cycles after the cycle in which symbol nSF-1 is accepted. o_re/o_im update in that same cycle and hold until the next o_valid. DRAIN then returns to IDLE.
- i_start while in ACCUM or DRAIN: abort the current hop and restart with the new parameters, with no o_valid for the aborted hop. i_start takes priority over a simultaneous i_valid, and that sample is dropped.
- rst mid-hop: abort immediately, no o_valid, outputs return to reset values.
- nSF=1: a single sample with phi=0, so the result equals the input sign-extended, 2 cycles after acceptance.

Decomposition:
- Shared package pucch1_pkg holds:
  - the nSF-to-amplifier constants (0,12,8,4);
  - the nSF=4 OCC LUT, shared with the spreader;
  - the supported-nSF check function;
  - the state enum.
- Sub-module cyc_24_pucch1_rot6: a combinational 6-entry cos/sin ROM indexed by k (3 bits), CW-parameterised.

Test Plan:
- nSF=2, occi=1, samples (100,0),(-100,0) -> phi 0,12; o_valid 2 cycles after the 2nd sample; o=(200,0); o_busy low afterwards.
- nSF=4, occi=3, samples (1,0),(-1,0),(-1,0),(1,0) -> o=(4,0). The same samples with occi=1 -> o=(0,0).
- nSF=3, occi=1, samples 1000*exp(j*2*pi*{0,8,16}/24) quantised -> o=(3000,0) within +/-2 LSB per component.
- nSF=6, occi=0, six samples (10,20) with i_valid gaps of 0-3 cycles between them -> o=(60,120); o_valid is single-cycle and occurs exactly once.
- nSF=5, and separately nSF=3 with occi=3 -> o_err pulse one cycle after i_start; o_busy stays 0; no o_valid.
- Restart and reset: i_start (nSF=6) with 3 samples, then i_start (nSF=2, occi=0) with (5,5),(5,5) -> a single o_valid with (10,10). Separately, rst during ACCUM -> o_busy=0 next cycle and no o_valid.

Source files
------------

// File: rtl/pucch1_pkg.sv
// Shared PUCCH format 1 definitions: OCC phase constants, nSF=4 cover LUT,
// nSF support check and the despreader state encoding.
package pucch1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN
  } state_t;

  // Row = occi, bit m = 1 where the nSF=4 cover applies a phase of 12 (i.e. -1).
  localparam logic [3:0][3:0] OCC4_LUT = {4'b0110, 4'b1100, 4'b1010, 4'b0000};

  function automatic logic nsf_supported(input logic [2:0] nsf);
    return (nsf == 3'd1) || (nsf == 3'd2) || (nsf == 3'd3) ||
           (nsf == 3'd4) || (nsf == 3'd6);
  endfunction

  // Per-symbol phase increment multiplier A, in units of 2*pi/24.
  function automatic logic [4:0] nsf_amp(input logic [2:0] nsf);
    case (nsf)
      3'd2:    return 5'd12;
      3'd3:    return 5'd8;
      3'd6:    return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  // occi*A is always below 24 for legal (nSF, occi) pairs.
  function automatic logic [4:0] phase_step(input logic [2:0] nsf, input logic [2:0] occi);
    return 5'(nsf_amp(nsf) * {2'b00, occi});
  endfunction

endpackage

// File: rtl/cyc_24_pucch1_rot6.sv
// Combinational cos/sin ROM for the six phases 2*pi*k/6, scaled so 1.0 = 2^(CW-2).
module cyc_24_pucch1_rot6 #(
  parameter int CW = 16
) (
  input  logic [2:0]           k,
  output logic signed [CW-1:0] c,
  output logic signed [CW-1:0] s
);

  localparam int ONE_I = 2 ** (CW - 2);
  localparam int S60_I = int'(0.8660254037844386 * real'(ONE_I));
  localparam logic signed [CW-1:0] ONE  = CW'(ONE_I);
  localparam logic signed [CW-1:0] HALF = CW'(ONE_I / 2);
  localparam logic signed [CW-1:0] S60  = CW'(S60_I);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    c = ONE;
    s = '0;
    case (k)
      3'd1: begin c =  HALF; s =  S60; end
      3'd2: begin c = -HALF; s =  S60; end
      3'd3: begin c = -ONE;  s = '0;   end
      3'd4: begin c = -HALF; s = -S60; end
      3'd5: begin c =  HALF; s = -S60; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cyc_24_pucch1_despread.sv
// PUCCH format 1 OCC despreader: derotates each symbol by conj(wi(m)) and
// coherently sums one hop into a single complex statistic.
module cyc_24_pucch1_despread
  import pucch1_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16,
  parameter int OW = W + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [2:0]           i_nSF,
  input  logic [2:0]           i_occi,
  input  logic                 i_valid,
  input  logic signed [W-1:0]  i_re,
  input  logic signed [W-1:0]  i_im,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_re,
  output logic signed [OW-1:0] o_im,
  output logic                 o_err
);

  localparam int PW = W + CW + 1;
  localparam logic signed [PW-1:0] RND = {{(PW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};

  state_t     state;
  logic [2:0] nsf_q;
  logic [1:0] occ4_q;
  logic [2:0] m_q;
  logic [4:0] phi_q;
  logic [4:0] step_q;

  logic                 p_vld, p_last;
  logic signed [OW-1:0] p_re, p_im;
  logic signed [OW-1:0] acc_re, acc_im;

  logic                 params_ok, accept, last;
  logic [2:0]           k;
  logic [5:0]           phi_sum;
  logic [4:0]           phi_next;
  logic signed [CW-1:0] c, s;
  logic signed [PW-1:0] xr_e, xi_e, c_e, s_e, mul_re, mul_im;
  logic signed [OW-1:0] d_re, d_im;

  cyc_24_pucch1_rot6 #(.CW(CW)) u_rot (
    .k (k),
    .c (c),
    .s (s)
  );

  always_comb begin
    params_ok = nsf_supported(i_nSF) && (i_occi < i_nSF);
    accept    = (state == ST_ACCUM) && i_valid && !i_start;
    last      = accept && (m_q == nsf_q - 3'd1);
    phi_sum   = {1'b0, phi_q} + {1'b0, step_q};
    phi_next  = (phi_sum >= 6'd24) ? 5'(phi_sum - 6'd24) : phi_sum[4:0];
    // Every phase is a multiple of 4, so the ROM index is phi/4.
    if (nsf_q == 3'd4) k = OCC4_LUT[occ4_q][m_q[1:0]] ? 3'd3 : 3'd0;
    else               k = 3'(phi_q >> 2);
    xr_e   = PW'(i_re);
    xi_e   = PW'(i_im);
    c_e    = PW'(c);
    s_e    = PW'(s);
    mul_re = xr_e * c_e + xi_e * s_e;
    mul_im = xi_e * c_e - xr_e * s_e;
    d_re   = OW'((mul_re + RND) >>> (CW - 2));
    d_im   = OW'((mul_im + RND) >>> (CW - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      nsf_q   <= '0;
      occ4_q  <= '0;
      m_q     <= '0;
      phi_q   <= '0;
      step_q  <= '0;
      p_vld   <= 1'b0;
      p_last  <= 1'b0;
      p_re    <= '0;
      p_im    <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; pulses default low here.
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      p_vld   <= 1'b0;
      p_last  <= 1'b0;
      if (i_start) begin
        // A new start aborts any hop in flight, including a pending result.
        acc_re <= '0;
        acc_im <= '0;
        m_q    <= '0;
        phi_q  <= '0;
        if (params_ok) begin
          nsf_q  <= i_nSF;
          occ4_q <= i_occi[1:0];
          step_q <= phase_step(i_nSF, i_occi);
          state  <= ST_ACCUM;
          o_busy <= 1'b1;
        end else begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_err  <= 1'b1;
        end
      end else begin
        if (accept) begin
          p_vld  <= 1'b1;
          p_last <= last;
          p_re   <= d_re;
          p_im   <= d_im;
          m_q    <= m_q + 3'd1;
          phi_q  <= phi_next;
          if (last) begin
            state  <= ST_DRAIN;
            o_busy <= 1'b0;
          end
        end
        if (p_vld) begin
          acc_re <= acc_re + p_re;
          acc_im <= acc_im + p_im;
          if (p_last) begin
            o_valid <= 1'b1;
            o_re    <= acc_re + p_re;
            o_im    <= acc_im + p_im;
            state   <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
